fwd_hazard_unit: RTL

- Parametrised next-generation forwarding/hazard unit for the in-order pipeline, sitting beside the ID stage.
- Compares the source registers of N decode-stage operands against the EX, MEM and WB destinations.
- Produces per-operand forward selects and forwarded data.
- Runs a load-use stall state machine with a configurable stall length, and drives bubble insertion into EX.

---
 rtl/fwd_hazard_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall control beside the ID stage.
// Optional feature macro: FWD_HOLD_EN (one-cycle post-WB hold register).
module fwd_hazard_unit #(
    parameter int DATA_W   = 10,
    parameter int REG_AW   = 3,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_regs,
    input  logic                      ex_wr_en,
    input  logic                      ex_is_load,
    input  logic [REG_AW-1:0]         ex_dest_reg,
    input  logic                      mem_wr_en,
    input  logic [REG_AW-1:0]         mem_dest_reg,
    input  logic [DATA_W-1:0]         mem_data,
    input  logic                      wb_wr_en,
    input  logic [REG_AW-1:0]         wb_dest_reg,
    input  logic [DATA_W-1:0]         wb_data,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic [NUM_SRC*DATA_W-1:0] fwd_data,
    output logic                      stall,
    output logic                      flush_ex
);

    localparam int CW = 3;

    typedef enum logic {
        IDLE,
        STALL
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [NUM_SRC-1:0]   w_ex_hit;
    logic                 w_hazard;

`ifdef FWD_HOLD_EN
    logic                 r_hold_valid;
    logic [REG_AW-1:0]    r_hold_reg;
    logic [DATA_W-1:0]    r_hold_data;
    logic                 w_wb_nz;

    assign w_wb_nz = !((ZERO_REG != 0) && (wb_dest_reg == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_valid <= 1'b0;
            r_hold_reg   <= '0;
            r_hold_data  <= '0;
        end else if (wb_wr_en && w_wb_nz) begin
            r_hold_valid <= 1'b1;
            r_hold_reg   <= wb_dest_reg;
            r_hold_data  <= wb_data;
        end else begin
            r_hold_valid <= 1'b0;
        end
    end
`endif

    // Youngest producer wins: MEM, then WB, then the post-WB hold copy.
    always_comb begin
        fwd_sel  = '0;
        fwd_data = '0;
        w_ex_hit = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            logic [REG_AW-1:0] w_src;
            logic              w_nz;
            w_src = id_src_regs[k*REG_AW +: REG_AW];
            w_nz  = !((ZERO_REG != 0) && (w_src == '0));
            if (id_valid && w_nz) begin
                w_ex_hit[k] = ex_wr_en && (ex_dest_reg == w_src);
                if (mem_wr_en && (mem_dest_reg == w_src)) begin
                    fwd_sel[k*2 +: 2]          = 2'b01;
                    fwd_data[k*DATA_W +: DATA_W] = mem_data;
                end else if (wb_wr_en && (wb_dest_reg == w_src)) begin
                    fwd_sel[k*2 +: 2]          = 2'b10;
                    fwd_data[k*DATA_W +: DATA_W] = wb_data;
                end
`ifdef FWD_HOLD_EN
                else if (r_hold_valid && (r_hold_reg == w_src)) begin
                    fwd_sel[k*2 +: 2]          = 2'b11;
                    fwd_data[k*DATA_W +: DATA_W] = r_hold_data;
                end
`endif
            end
        end
    end

    assign w_hazard = id_valid && ex_is_load && (|w_ex_hit);

    // The detecting cycle stalls combinationally; STALL covers the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_hazard && (LOAD_LAT > 1)) begin
                        r_state <= STALL;
                        r_cnt   <= CW'(LOAD_LAT - 1);
                    end
                end
                STALL: begin
                    if (r_cnt <= CW'(1)) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign stall    = rst_n && ((r_state == STALL) || w_hazard);
    assign flush_ex = stall;

endmodule
